uart_wb_master: RTL and testbench

UART_WB_MASTER -- requirements
Module: uart_wb_master

---
 rtl/uart_wb_pkg.sv | 23 ++
 rtl/wb_ack_watchdog.sv | 30 +++
 rtl/uart_wb_master.sv | 189 ++++++++++++++++++
 tb/tb_uart_wb_master.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_wb_pkg.sv
// rtl/uart_wb_pkg.sv - shared FSM state type and default register offsets for uart_wb_master
package uart_wb_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    RD_TXBUSY = 3'd1,
    WR_TXDATA = 3'd2,
    RD_RXFULL = 3'd3,
    RD_RXDATA = 3'd4,
    GAP       = 3'd5
  } wb_state_t;

  localparam int unsigned TX_BUSY_OFS = 0;
  localparam int unsigned RX_FULL_OFS = 4;
  localparam int unsigned RX_DATA_OFS = 8;
  localparam int unsigned TX_DATA_OFS = 12;

  // States in which a Wishbone cycle is open (cyc/stb asserted).
  function automatic logic is_bus_state(input wb_state_t s);
    return (s == RD_TXBUSY) || (s == WR_TXDATA) || (s == RD_RXFULL) || (s == RD_RXDATA);
  endfunction

endpackage

// File: rtl/wb_ack_watchdog.sv
// rtl/wb_ack_watchdog.sv - counts un-acked bus cycles and flags expiry at LIMIT
module wb_ack_watchdog #(
  parameter int unsigned LIMIT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic run,
  output logic expired
);

  localparam int unsigned CW = (LIMIT < 2) ? 1 : $clog2(LIMIT + 1);

  logic [CW-1:0] r_count;

  // Cycle counter: restarts whenever the transfer ends or is acked.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (run && !expired) begin
      r_count <= r_count + 1'b1;
    end
  end

  // Expires during the LIMIT-th consecutive waiting cycle.
  assign expired = run && (r_count >= CW'(LIMIT - 1));

endmodule

// File: rtl/uart_wb_master.sv
// rtl/uart_wb_master.sv - UART-to-Wishbone bridge master; optional ack watchdog via UART_WB_MASTER_TIMEOUT_EN
module uart_wb_master
  import uart_wb_pkg::*;
#(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned TX_BUSY_ADDR = TX_BUSY_OFS,
  parameter int unsigned RX_FULL_ADDR = RX_FULL_OFS,
  parameter int unsigned RX_DATA_ADDR = RX_DATA_OFS,
  parameter int unsigned TX_DATA_ADDR = TX_DATA_OFS,
  parameter int unsigned ACK_TIMEOUT  = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tx_valid,
  input  logic [7:0]        tx_byte,
  output logic              tx_ready,
  output logic              rx_valid,
  output logic [7:0]        rx_byte,
  input  logic              rx_ready,
  output logic              o_wb_cyc,
  output logic              o_wb_stb,
  output logic              o_wb_we,
  output logic [ADDR_W-1:0] o_wb_addr,
  output logic [31:0]       o_wb_data,
  input  logic [31:0]       i_wb_data,
  input  logic              i_wb_ack,
  output logic              err
);

  localparam logic [ADDR_W-1:0] A_TX_BUSY = ADDR_W'(TX_BUSY_ADDR);
  localparam logic [ADDR_W-1:0] A_RX_FULL = ADDR_W'(RX_FULL_ADDR);
  localparam logic [ADDR_W-1:0] A_RX_DATA = ADDR_W'(RX_DATA_ADDR);
  localparam logic [ADDR_W-1:0] A_TX_DATA = ADDR_W'(TX_DATA_ADDR);

  wb_state_t         r_state;
  wb_state_t         r_after_gap;
  logic [7:0]        r_tx_byte;
  logic              r_rx_valid;
  logic [7:0]        r_rx_byte;

  wb_state_t         w_state_nxt;
  wb_state_t         w_after_gap_nxt;
  logic              w_bus;
  logic              w_ack_ok;
  logic              w_we;
  logic [ADDR_W-1:0] w_addr;
  logic [31:0]       w_wdata;
  logic              w_tx_ready;
  logic              w_tx_load;
  logic              w_rx_load;
  logic              w_wd_expired;
  logic              w_unused;

  assign w_bus    = is_bus_state(r_state);
  // Ack only means something while our cycle is open.
  assign w_ack_ok = w_bus && i_wb_ack;

`ifdef UART_WB_MASTER_TIMEOUT_EN
  logic w_wd_clear;
  logic w_wd_run;
  logic r_err;

  assign w_wd_clear = !w_bus || i_wb_ack;
  assign w_wd_run   = w_bus && !i_wb_ack;

  wb_ack_watchdog #(
    .LIMIT (ACK_TIMEOUT)
  ) u_watchdog (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (w_wd_clear),
    .run     (w_wd_run),
    .expired (w_wd_expired)
  );

  // One-cycle error pulse in the GAP cycle following an abandoned transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else begin
      r_err <= w_wd_expired;
    end
  end

  assign err      = r_err;
  assign w_unused = ^i_wb_data[31:8];
`else
  assign w_wd_expired = 1'b0;
  assign err          = 1'b0;
  assign w_unused     = ^i_wb_data[31:8] ^ (^32'(ACK_TIMEOUT));
`endif

  // State, after-GAP target and data registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_after_gap <= IDLE;
      r_tx_byte   <= 8'h00;
      r_rx_valid  <= 1'b0;
      r_rx_byte   <= 8'h00;
    end else begin
      r_state     <= w_state_nxt;
      r_after_gap <= w_after_gap_nxt;
      if (w_tx_load) begin
        r_tx_byte <= tx_byte;
      end
      if (w_rx_load) begin
        r_rx_valid <= 1'b1;
        r_rx_byte  <= i_wb_data[7:0];
      end else if (r_rx_valid && rx_ready) begin
        r_rx_valid <= 1'b0;
      end
    end
  end

  // Next-state and bus output decode.
  always_comb begin
    w_state_nxt     = r_state;
    w_after_gap_nxt = r_after_gap;
    w_we            = 1'b0;
    w_addr          = '0;
    w_wdata         = 32'h0;
    w_tx_ready      = 1'b0;
    w_tx_load       = 1'b0;
    w_rx_load       = 1'b0;
    case (r_state)
      IDLE: begin
        w_tx_ready = 1'b1;
        if (tx_valid) begin
          w_tx_load   = 1'b1;
          w_state_nxt = RD_TXBUSY;
        end else if (!r_rx_valid) begin
          w_state_nxt = RD_RXFULL;
        end
      end
      RD_TXBUSY: begin
        w_addr = A_TX_BUSY;
        if (w_ack_ok) begin
          w_state_nxt     = GAP;
          w_after_gap_nxt = i_wb_data[0] ? RD_TXBUSY : WR_TXDATA;
        end
      end
      WR_TXDATA: begin
        w_we    = 1'b1;
        w_addr  = A_TX_DATA;
        w_wdata = {24'h0, r_tx_byte};
        if (w_ack_ok) begin
          w_state_nxt     = GAP;
          w_after_gap_nxt = IDLE;
        end
      end
      RD_RXFULL: begin
        w_addr = A_RX_FULL;
        if (w_ack_ok) begin
          w_state_nxt     = GAP;
          w_after_gap_nxt = i_wb_data[0] ? RD_RXDATA : IDLE;
        end
      end
      RD_RXDATA: begin
        w_addr = A_RX_DATA;
        if (w_ack_ok) begin
          w_rx_load       = 1'b1;
          w_state_nxt     = GAP;
          w_after_gap_nxt = IDLE;
        end
      end
      GAP: begin
        w_state_nxt = r_after_gap;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
    if (w_wd_expired) begin
      w_state_nxt     = GAP;
      w_after_gap_nxt = IDLE;
    end
  end

  assign tx_ready  = w_tx_ready;
  assign rx_valid  = r_rx_valid;
  assign rx_byte   = r_rx_byte;
  assign o_wb_cyc  = w_bus;
  assign o_wb_stb  = w_bus;
  assign o_wb_we   = w_we;
  assign o_wb_addr = w_addr;
  assign o_wb_data = w_wdata;

endmodule

// File: tb/tb_uart_wb_master.sv
// tb/tb_uart_wb_master.sv - scoreboard bench for uart_wb_master; timeout case under UART_WB_MASTER_TIMEOUT_EN
module tb_uart_wb_master;

  localparam logic [31:0] A_TX_BUSY = 32'd0;
  localparam logic [31:0] A_RX_FULL = 32'd4;
  localparam logic [31:0] A_RX_DATA = 32'd8;
  localparam logic [31:0] A_TX_DATA = 32'd12;

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [31:0] data;
  } xfer_t;

  logic        clk;
  logic        rst_n;
  logic        tx_valid;
  logic [7:0]  tx_byte;
  logic        tx_ready;
  logic        rx_valid;
  logic [7:0]  rx_byte;
  logic        rx_ready;
  logic        o_wb_cyc;
  logic        o_wb_stb;
  logic        o_wb_we;
  logic [31:0] o_wb_addr;
  logic [31:0] o_wb_data;
  logic [31:0] i_wb_data;
  logic        i_wb_ack;
  logic        err;

  int          tests;
  int          fails;
  xfer_t       exp_q[$];
  logic [7:0]  rx_q[$];
  logic [31:0] busy_q[$];
  logic        ack_en;
  int          ack_delay;
  logic        rx_full_flag;
  logic [31:0] rx_data_val;
  logic        skip_polls;
  logic        err_seen;

  uart_wb_master #(
    .ADDR_W      (32),
    .ACK_TIMEOUT (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .tx_valid  (tx_valid),
    .tx_byte   (tx_byte),
    .tx_ready  (tx_ready),
    .rx_valid  (rx_valid),
    .rx_byte   (rx_byte),
    .rx_ready  (rx_ready),
    .o_wb_cyc  (o_wb_cyc),
    .o_wb_stb  (o_wb_stb),
    .o_wb_we   (o_wb_we),
    .o_wb_addr (o_wb_addr),
    .o_wb_data (o_wb_data),
    .i_wb_data (i_wb_data),
    .i_wb_ack  (i_wb_ack),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_xfer(input logic [31:0] addr, input logic we, input logic [31:0] data);
    xfer_t x;
    x.addr = addr;
    x.we   = we;
    x.data = data;
    exp_q.push_back(x);
  endtask

  task automatic tick();
    @(negedge clk);
    #2;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    tx_valid = 1'b1;
    tx_byte  = b;
    n = 0;
    while (!tx_ready && n < 200) begin
      tick();
      n++;
    end
    check("tx_accept_in_time", {127'b0, tx_ready}, 128'd1);
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || rx_q.size() != 0) && n < 400) begin
      tick();
      n++;
    end
    check(name, 128'(exp_q.size() + rx_q.size()), 128'd0);
  endtask

  // Wishbone slave model: acks after ack_delay waiting cycles, register file from bench state
  initial begin : slave
    int wait_cnt;
    wait_cnt  = 0;
    i_wb_ack  = 1'b0;
    i_wb_data = 32'h0;
    forever begin
      @(negedge clk);
      if (i_wb_ack) begin
        i_wb_ack  = 1'b0;
        i_wb_data = 32'h0;
        wait_cnt  = 0;
      end else if (o_wb_cyc && ack_en) begin
        if (wait_cnt >= ack_delay) begin
          i_wb_ack = 1'b1;
          wait_cnt = 0;
          if (o_wb_we) begin
            i_wb_data = 32'h0;
          end else if (o_wb_addr == A_TX_BUSY) begin
            i_wb_data = (busy_q.size() != 0) ? busy_q.pop_front() : 32'h0;
          end else if (o_wb_addr == A_RX_FULL) begin
            i_wb_data    = {31'h0, rx_full_flag};
            rx_full_flag = 1'b0;
          end else if (o_wb_addr == A_RX_DATA) begin
            i_wb_data = rx_data_val;
          end else begin
            i_wb_data = 32'hDEADBEEF;
          end
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  // Bus scoreboard: every completed transfer is matched against the expected queue
  initial begin : sb_bus
    xfer_t a;
    xfer_t e;
    forever begin
      @(negedge clk);
      #1;
      if (rst_n && o_wb_cyc && i_wb_ack &&
          !(skip_polls && !o_wb_we && o_wb_addr == A_RX_FULL && i_wb_data[0] == 1'b0)) begin
        a.addr = o_wb_addr;
        a.we   = o_wb_we;
        a.data = o_wb_data;
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL bus_xfer: got %0h expected no transfer", a);
        end else begin
          e = exp_q.pop_front();
          check("bus_xfer", 128'(a), 128'(e));
        end
      end
    end
  end

  // RX scoreboard: compare the byte on each completed rx handshake
  initial begin : sb_rx
    logic [7:0] e;
    forever begin
      @(negedge clk);
      #1;
      if (rst_n && rx_valid && rx_ready) begin
        if (rx_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL rx_byte: got %0h expected no byte", rx_byte);
        end else begin
          e = rx_q.pop_front();
          check("rx_byte", 128'(rx_byte), 128'(e));
        end
      end
    end
  end

  // Protocol monitor: request held stable until ack, cyc dropped right after ack
  initial begin : proto
    logic        p_cyc;
    logic        p_ack;
    logic        p_we;
    logic [31:0] p_addr;
    logic [31:0] p_data;
    p_cyc  = 1'b0;
    p_ack  = 1'b0;
    p_we   = 1'b0;
    p_addr = 32'h0;
    p_data = 32'h0;
    forever begin
      @(negedge clk);
      #1;
      if (err) err_seen = 1'b1;
      if (!rst_n) begin
        p_cyc = 1'b0;
        p_ack = 1'b0;
      end else begin
        if (p_cyc && !p_ack && o_wb_cyc)
          check("req_stable", {o_wb_addr, o_wb_we, o_wb_data, o_wb_stb}, {p_addr, p_we, p_data, 1'b1});
        if (p_cyc && p_ack)
          check("cyc_drop_after_ack", {127'b0, o_wb_cyc}, 128'd0);
        p_cyc  = o_wb_cyc;
        p_ack  = i_wb_ack;
        p_we   = o_wb_we;
        p_addr = o_wb_addr;
        p_data = o_wb_data;
      end
    end
  end

  initial begin : global_limit
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin : stim
    int n;
    int cnt;
    tests        = 0;
    fails        = 0;
    rst_n        = 1'b0;
    tx_valid     = 1'b0;
    tx_byte      = 8'h00;
    rx_ready     = 1'b0;
    ack_en       = 1'b1;
    ack_delay    = 0;
    rx_full_flag = 1'b0;
    rx_data_val  = 32'h0;
    skip_polls   = 1'b1;
    err_seen     = 1'b0;

    // Reset state
    repeat (3) tick();
    check("rst_cyc", {126'b0, o_wb_cyc, o_wb_stb}, 128'd0);
    check("rst_we_addr_data", {o_wb_we, o_wb_addr, o_wb_data}, 128'd0);
    check("rst_rx", {119'b0, rx_valid, rx_byte}, 128'd0);
    check("rst_err", {127'b0, err}, 128'd0);
    check("rst_tx_ready_idle", {127'b0, tx_ready}, 128'd1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) tick();

    // TX with busy 1,1,0 then write of 0x5A
    busy_q = '{32'h1, 32'h1, 32'h0};
    push_xfer(A_TX_BUSY, 1'b0, 32'h0);
    push_xfer(A_TX_BUSY, 1'b0, 32'h0);
    push_xfer(A_TX_BUSY, 1'b0, 32'h0);
    push_xfer(A_TX_DATA, 1'b1, 32'h0000005A);
    send_byte(8'h5A);
    wait_drain("tx_5a_drain");
    tick();
    check("tx_gap_cyc_low", {127'b0, o_wb_cyc}, 128'd0);
    tick();
    check("tx_ready_after_write", {127'b0, tx_ready}, 128'd1);

    // Delayed ack: request stability and a single-cycle gap
    ack_delay = 5;
    busy_q = '{32'h0};
    push_xfer(A_TX_BUSY, 1'b0, 32'h0);
    push_xfer(A_TX_DATA, 1'b1, 32'h000000C3);
    send_byte(8'hC3);
    n = 0;
    while (!(o_wb_cyc && i_wb_ack && o_wb_addr == A_TX_BUSY) && n < 100) begin
      tick();
      n++;
    end
    check("slow_busy_ack_seen", {127'b0, i_wb_ack}, 128'd1);
    tick();
    check("slow_gap_low", {127'b0, o_wb_cyc}, 128'd0);
    tick();
    check("slow_gap_one_cycle", {126'b0, o_wb_cyc, o_wb_we}, 128'd3);
    wait_drain("slow_drain");
    ack_delay = 0;

    // RX: byte 0x34 held until rx_ready, no polling meanwhile
    rx_data_val  = 32'hABCD1234;
    push_xfer(A_RX_FULL, 1'b0, 32'h0);
    push_xfer(A_RX_DATA, 1'b0, 32'h0);
    rx_q.push_back(8'h34);
    rx_full_flag = 1'b1;
    n = 0;
    while (!rx_valid && n < 100) begin
      tick();
      n++;
    end
    check("rx_valid_seen", {127'b0, rx_valid}, 128'd1);
    cnt = 0;
    repeat (20) begin
      tick();
      if (o_wb_cyc) cnt++;
    end
    check("rx_hold_no_bus", 128'(cnt), 128'd0);
    check("rx_hold_value", {119'b0, rx_valid, rx_byte}, {119'b0, 1'b1, 8'h34});
    @(negedge clk);
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
    #2;
    check("rx_valid_cleared", {127'b0, rx_valid}, 128'd0);
    wait_drain("rx_drain");

    // TX arriving during an RX_FULL read: RX finishes first
    ack_delay    = 3;
    rx_ready     = 1'b1;
    rx_data_val  = 32'h00000077;
    busy_q       = '{32'h0};
    push_xfer(A_RX_FULL, 1'b0, 32'h0);
    push_xfer(A_RX_DATA, 1'b0, 32'h0);
    push_xfer(A_TX_BUSY, 1'b0, 32'h0);
    push_xfer(A_TX_DATA, 1'b1, 32'h00000011);
    rx_q.push_back(8'h77);
    rx_full_flag = 1'b1;
    n = 0;
    while (!(o_wb_cyc && o_wb_addr == A_RX_FULL && !i_wb_ack) && n < 100) begin
      tick();
      n++;
    end
    check("mix_in_rxfull", {96'b0, o_wb_addr}, {96'b0, A_RX_FULL});
    check("mix_tx_ready_low", {127'b0, tx_ready}, 128'd0);
    skip_polls = 1'b0;
    send_byte(8'h11);
    wait_drain("mix_drain");
    skip_polls = 1'b1;
    rx_ready   = 1'b0;

    // Reset during WR_TXDATA abandons the write
    ack_delay = 6;
    busy_q = '{32'h0};
    push_xfer(A_TX_BUSY, 1'b0, 32'h0);
    send_byte(8'h99);
    n = 0;
    while (!(o_wb_cyc && o_wb_we) && n < 100) begin
      tick();
      n++;
    end
    check("rstmid_in_write", {127'b0, o_wb_we}, 128'd1);
    rst_n = 1'b0;
    #1;
    check("rstmid_cyc_low", {125'b0, o_wb_cyc, o_wb_stb, o_wb_we}, 128'd0);
    check("rstmid_idle", {127'b0, tx_ready}, 128'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    repeat (40) begin
      tick();
      if (o_wb_we) cnt++;
    end
    check("rstmid_no_write", 128'(cnt), 128'd0);
    wait_drain("rstmid_drain");
    ack_delay = 0;

`ifdef UART_WB_MASTER_TIMEOUT_EN
    // No ack: watchdog drops the cycle after 4 cycles and pulses err once
    ack_en = 1'b0;
    n = 0;
    while (o_wb_cyc && n < 50) begin
      tick();
      n++;
    end
    n = 0;
    while (!o_wb_cyc && n < 50) begin
      tick();
      n++;
    end
    cnt = 0;
    while (o_wb_cyc && cnt < 20) begin
      tick();
      cnt++;
    end
    check("wd_cyc_cycles", 128'(cnt), 128'd4);
    check("wd_err_pulse", {127'b0, err}, 128'd1);
    tick();
    check("wd_err_single", {127'b0, err}, 128'd0);
    check("wd_back_idle", {127'b0, tx_ready}, 128'd1);
    ack_en = 1'b1;
    repeat (10) tick();
`else
    check("err_never_set", {127'b0, err_seen}, 128'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
